// File: rtl/char_pixel_if.sv
// char_pixel_if
//   Bundles the signals between the VGA timing generator / text buffer /
//   glyph array and the character pixel reader.
//   master : timing generator side; drives frame_start, line_end, pixel_en,
//            char_code and glyph_bits, and observes addresses and the pixel.
//   slave  : char_pixel_reader side.
//   Signals:
//     frame_start  pulse before the first active line of a frame
//     line_end     pulse after the last active pixel of a line
//     pixel_en     an active pixel is consumed this cycle
//     char_code    code of the cell at (col,row), from the text buffer
//     glyph_bits   glyph array read data, bit i = glyph i
//     glyph_x/y    glyph array read address
//     col/row      current text cell (COLS / ROWS mean off the text area)
//     pixel_out    rendered mono pixel
//     pixel_valid  pixel_out belongs to the previous cycle's pixel_en
interface char_pixel_if #(
  parameter int COLS = 32,
  parameter int ROWS = 20
);
  localparam int CW = $clog2(COLS + 1);
  localparam int RW = $clog2(ROWS + 1);

  logic          frame_start;
  logic          line_end;
  logic          pixel_en;
  logic [5:0]    char_code;
  logic [35:0]   glyph_bits;
  logic [1:0]    glyph_x;
  logic [2:0]    glyph_y;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          pixel_out;
  logic          pixel_valid;

  modport master (
    output frame_start, line_end, pixel_en, char_code, glyph_bits,
    input  glyph_x, glyph_y, col, row, pixel_out, pixel_valid
  );

  modport slave (
    input  frame_start, line_end, pixel_en, char_code, glyph_bits,
    output glyph_x, glyph_y, col, row, pixel_out, pixel_valid
  );
endinterface

// File: rtl/char_pixel_reader.sv
// char_pixel_reader
//   Read-side sequencer for the 36-glyph character array. Tracks the
//   active-pixel position as text cell (col,row), glyph pixel (cx,cy) and
//   replication phase (sub_x,sub_y); drives the array x/y address; picks the
//   addressed glyph's bit and emits one registered pixel per active pixel.
//   Ports:
//     clock  rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    char_pixel_if slave modport (see interface for signal list)
//   Cell layout is 5x6 glyph pixels: 4x5 glyph, gap column cx=4, gap row
//   cy=5. Each glyph pixel covers SCALE x SCALE screen pixels.
module char_pixel_reader #(
  parameter int SCALE = 4,
  parameter int COLS  = 32,
  parameter int ROWS  = 20
) (
  input  logic       clock,
  input  logic       rst_n,
  char_pixel_if.slave bus
);
  localparam int CW  = $clog2(COLS + 1);
  localparam int RW  = $clog2(ROWS + 1);
  localparam int SXW = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [SXW-1:0] SUB_LAST = SXW'(SCALE - 1);
  localparam logic [CW-1:0]  COL_END  = CW'(COLS);
  localparam logic [RW-1:0]  ROW_END  = RW'(ROWS);

  logic [SXW-1:0] sub_x;
  logic [SXW-1:0] sub_y;
  logic [2:0]     cx;
  logic [2:0]     cy;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic           out_pixel;
  logic           out_valid;

  logic           col_end;
  logic           row_end;
  logic           sel;
  logic [63:0]    bits_ext;

  assign col_end = (col == COL_END);
  assign row_end = (row == ROW_END);

  // Zero-extend so any 6-bit code indexes a real bit; codes 36..63 read 0.
  assign bits_ext = {28'd0, bus.glyph_bits};

  assign sel = !col_end && !row_end && (cx < 3'd4) && (cy < 3'd5)
               && (bus.char_code < 6'd36) && bits_ext[bus.char_code];

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      sub_x     <= '0;
      cx        <= '0;
      col       <= '0;
      sub_y     <= '0;
      cy        <= '0;
      row       <= '0;
      out_pixel <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // Pixel is rendered from the pre-update counters regardless of what
      // frame_start / line_end do to them on this edge.
      out_valid <= bus.pixel_en;
      out_pixel <= bus.pixel_en & sel;

      if (bus.frame_start) begin
        sub_x <= '0;
        cx    <= '0;
        col   <= '0;
        sub_y <= '0;
        cy    <= '0;
        row   <= '0;
      end else if (bus.line_end) begin
        sub_x <= '0;
        cx    <= '0;
        col   <= '0;
        // Below the text area the vertical counters freeze with cy = 0.
        if (!row_end) begin
          if (sub_y == SUB_LAST) begin
            sub_y <= '0;
            if (cy == 3'd5) begin
              cy  <= '0;
              row <= row + RW'(1);
            end else begin
              cy <= cy + 3'd1;
            end
          end else begin
            sub_y <= sub_y + SXW'(1);
          end
        end
      end else if (bus.pixel_en && !col_end) begin
        if (sub_x == SUB_LAST) begin
          sub_x <= '0;
          if (cx == 3'd4) begin
            cx  <= '0;
            col <= col + CW'(1);
          end else begin
            cx <= cx + 3'd1;
          end
        end else begin
          sub_x <= sub_x + SXW'(1);
        end
      end
    end
  end

  assign bus.glyph_x     = (cx < 3'd4) ? cx[1:0] : 2'd0;
  assign bus.glyph_y     = (cy < 3'd5) ? cy : 3'd0;
  assign bus.col         = col;
  assign bus.row         = row;
  assign bus.pixel_out   = out_pixel;
  assign bus.pixel_valid = out_valid;
endmodule

// File: tb/tb_char_pixel_reader.sv
// tb_char_pixel_reader
//   Directed bench for char_pixel_reader. Expected pixels are pushed to a
//   queue when pixel_en is driven and popped when pixel_valid appears.
//   Expected addresses come from a position model: screen pixel index in the
//   line (px) and line index in the frame (ly), converted with division.
module tb_char_pixel_reader;
  localparam int SCALE  = 4;
  localparam int COLS   = 32;
  localparam int ROWS   = 20;
  localparam int CELL_W = 5 * SCALE;
  localparam int CELL_H = 6 * SCALE;

  logic clock = 1'b0;
  logic rst_n;

  char_pixel_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  char_pixel_reader #(.SCALE(SCALE), .COLS(COLS), .ROWS(ROWS)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int   vectors     = 0;
  int   miscompares = 0;
  int   px          = 0;
  int   ly          = 0;
  bit   exp_valid   = 1'b0;
  bit   sb[$];
  logic [5:0]  code;
  logic [35:0] bits;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (px=%0d ly=%0d)", tag, got, exp, px, ly);
    end
  endtask

  task automatic model(output int c, output int cxm, output int r, output int cym);
    int pxe, lye;
    pxe = (px > COLS * CELL_W) ? COLS * CELL_W : px;
    lye = (ly > ROWS * CELL_H) ? ROWS * CELL_H : ly;
    c   = pxe / CELL_W;
    cxm = (pxe / SCALE) % 5;
    r   = lye / CELL_H;
    cym = (lye / SCALE) % 6;
  endtask

  // One clock: check outputs of the previous edge, drive inputs, advance model.
  task automatic step(input bit rn, input bit fs, input bit le, input bit pe);
    int  c, cxm, r, cym;
    bit  exp_pix;
    bit  head;
    check("pixel_valid", {31'd0, bus.pixel_valid}, {31'd0, exp_valid});
    if (bus.pixel_valid === 1'b1) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL sb_empty: observed pixel_valid=1 expected no pending pixel");
      end
      if (sb.size() != 0) begin
        head = sb.pop_front();
        check("pixel_out", {31'd0, bus.pixel_out}, {31'd0, head});
      end
    end else begin
      check("pixel_out_idle", {31'd0, bus.pixel_out}, 32'd0);
    end
    model(c, cxm, r, cym);
    check("col", 32'(bus.col), c);
    check("row", 32'(bus.row), r);
    check("glyph_x", 32'(bus.glyph_x), (cxm < 4) ? cxm : 0);
    check("glyph_y", 32'(bus.glyph_y), (cym < 5) ? cym : 0);

    rst_n           = rn;
    bus.frame_start = fs;
    bus.line_end    = le;
    bus.pixel_en    = pe;
    bus.char_code   = code;
    bus.glyph_bits  = bits;
    exp_pix = (c < COLS) && (r < ROWS) && (cxm < 4) && (cym < 5)
              && (int'(code) < 36) && bits[int'(code) % 36];
    if (rn && pe) sb.push_back(exp_pix);
    exp_valid = rn && pe;
    if (!rn || fs) begin
      px = 0;
      ly = 0;
    end else if (le) begin
      px = 0;
      ly++;
    end else if (pe) begin
      px++;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    code            = 6'd0;
    bits            = '1;
    rst_n           = 1'b0;
    bus.frame_start = 1'b0;
    bus.line_end    = 1'b0;
    bus.pixel_en    = 1'b1;
    bus.char_code   = code;
    bus.glyph_bits  = bits;
    @(posedge clock);
    #1;

    // Reset held with pixel_en high: nothing may be emitted.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    // Release, new frame, horizontal sweep over two cells.
    step(1, 1, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 0, 0, 1);
    step(1, 0, 0, 0);

    // Code selection with only glyph 35 lit.
    step(1, 0, 1, 0);
    bits = 36'h8_0000_0000;
    code = 6'd0;  step(1, 0, 0, 1);
    code = 6'd34; step(1, 0, 0, 1);
    code = 6'd35; step(1, 0, 0, 1);
    code = 6'd36; step(1, 0, 0, 1);
    code = 6'd63; step(1, 0, 0, 1);
    code = 6'd35; step(1, 0, 0, 1);
    step(1, 0, 0, 0);

    // Vertical cascade: 24 lines to row 1, 20 more into the gap row.
    bits = '1;
    code = 6'd7;
    step(1, 1, 0, 0);
    for (int i = 0; i < 24; i++) step(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    step(1, 0, 1, 0);
    for (int i = 0; i < 19; i++) step(1, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1);

    // Right-edge saturation, then line_end together with pixel_en.
    code = 6'd0;
    step(1, 1, 0, 0);
    for (int i = 0; i < COLS * CELL_W + 10; i++) step(1, 0, 0, 1);
    step(1, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);

    // Precedence: frame_start with line_end at row 7, mid-cell vertically.
    for (int i = 0; i < 7 * CELL_H + 6; i++) step(1, 0, 1, 0);
    step(1, 0, 0, 1);
    step(1, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0);
    step(1, 0, 0, 1);
    // frame_start with pixel_en: pixel uses old position, then clear.
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
    for (int i = 0; i < 30; i++) step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    step(1, 0, 0, 1);

    // Reset mid-line at col 12.
    step(1, 0, 1, 0);
    for (int i = 0; i < 12 * CELL_W + 3; i++) step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
